// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and request legality helpers
// for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_ERR
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned forms; loads accept all five codes.
    function automatic logic legal_funct3(
        input logic       write,
        input logic [2:0] funct3
    );
        logic sized;
        sized = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        if (write) begin
            return sized;
        end
        return sized || (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    // Size lives in funct3[1:0]; halfwords need even, words need
    // 4-byte aligned addresses.
    function automatic logic misaligned(
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic bad;
        bad = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            bad = addr_lo[0];
        end else if (funct3[1:0] == 2'b10) begin
            bad = (addr_lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Byte/halfword lane logic: load extract/extend and store merge
// share one lane shift so both paths see the same lane position.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] lane;
    logic [31:0] mask;

    // Lane position: byte uses both offset bits, halfword only bit 1.
    always_comb begin
        shamt = 5'd0;
        mask  = 32'hFFFF_FFFF;
        case (funct3[1:0])
            2'b00: begin
                shamt = {offset, 3'b000};
                mask  = 32'h0000_00FF << shamt;
            end
            2'b01: begin
                shamt = {offset[1], 4'b0000};
                mask  = 32'h0000_FFFF << shamt;
            end
            default: begin
                shamt = 5'd0;
                mask  = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign lane = word >> shamt;

    // Load path: pick the lane and sign- or zero-extend it.
    always_comb begin
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
            F3_W:    load_data = lane;
            F3_BU:   load_data = {24'd0, lane[7:0]};
            F3_HU:   load_data = {16'd0, lane[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    // Store path: replace only the addressed lane of the old word.
    always_comb begin
        merged = (word & ~mask) | ((store_data << shamt) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time and drives a
// word-wide data memory, doing sub-word stores as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    lsu_state_t  state_next;
    logic        accept;
    logic        req_bad;
    logic        out_of_range;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] merge_q;
    logic [31:0] lane_word;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept = req_valid && req_ready;

    assign out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;

    assign req_bad = !legal_funct3(req_write, req_funct3)
                   || misaligned(req_funct3, req_addr[1:0])
                   || out_of_range;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; the request is only examined in IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        state_next = S_ERR;
                    end else if (!req_write) begin
                        state_next = S_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_next = S_STORE;
                    end else begin
                        state_next = S_RMW_RD;
                    end
                end
            end
            S_RMW_RD: state_next = S_RMW_WR;
            S_LOAD:   state_next = S_IDLE;
            S_STORE:  state_next = S_IDLE;
            S_RMW_WR: state_next = S_IDLE;
            S_ERR:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Memory strobes and write data come from the registered state only.
    always_comb begin
        req_ready = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'd0;
        unique case (state)
            S_IDLE:   req_ready = 1'b1;
            S_LOAD:   mem_read = 1'b1;
            S_RMW_RD: mem_read = 1'b1;
            S_STORE: begin
                mem_write = 1'b1;
                mem_wdata = r_wdata;
            end
            S_RMW_WR: begin
                mem_write = 1'b1;
                mem_wdata = merged;
            end
            S_ERR:    req_ready = 1'b0;
            default:  req_ready = 1'b0;
        endcase
    end

    assign mem_addr = {2'b00, r_addr[31:2]};

    // Request capture on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
        end else if (accept) begin
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // Old word for the merge, sampled only at the edge closing RMW_RD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            merge_q <= 32'd0;
        end else if (state == S_RMW_RD) begin
            merge_q <= mem_rdata;
        end
    end

    // mem_rdata is only looked at during LOAD; the merge word otherwise.
    assign lane_word = (state == S_LOAD) ? mem_rdata : merge_q;

    lsu_lane u_lane (
        .funct3     (r_funct3),
        .offset     (r_addr[1:0]),
        .word       (lane_word),
        .store_data (r_wdata),
        .load_data  (load_data),
        .merged     (merged)
    );

    // Response pulse in the cycle after the final access or error state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= (state == S_LOAD) || (state == S_STORE)
                       || (state == S_RMW_WR) || (state == S_ERR);
            resp_err   <= (state == S_ERR);
            resp_rdata <= (state == S_LOAD) ? load_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural memory
// and a response scoreboard.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] tb_mem [0:1023];
    int          cyc;
    int          rd_cnt;
    int          wr_cnt;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    int          n_assert;
    int          n_fail;
    int          last_accept;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_read ? tb_mem[mem_addr[9:0]] : 32'bz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            tb_mem[mem_addr[9:0]] <= mem_wdata;
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
        if (mem_read) begin
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            exp_t e;
            if (q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL unexpected_resp: observed resp_valid 1 expected 0");
            end else begin
                e = q.pop_front();
                check32({e.tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                check32({e.tag, "_rdata"}, resp_rdata, e.rdata);
                check32({e.tag, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    // lat is the spec cycle number of resp_valid with the accept edge as edge 0.
    task automatic issue(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e, input logic [31:0] rd, input int lat);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check32({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        last_accept = cyc;
        q.push_back('{tag: tag, err: e, rdata: rd, cyc: cyc + lat - 1});
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check32({tag, "_drain"}, q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        int rd0;
        int wr0;
        int acc1;
        n_assert    = 0;
        n_fail      = 0;
        cyc         = 0;
        rd_cnt      = 0;
        wr_cnt      = 0;
        last_waddr  = 32'd0;
        last_wdata  = 32'd0;
        last_accept = 0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_funct3  = 3'd0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;

        repeat (3) @(negedge clk);
        check32("rst_ready", {31'd0, req_ready}, 32'd1);
        check32("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check32("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check32("rst_resp_rdata", resp_rdata, 32'd0);
        check32("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check32("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        check32("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        wr0 = wr_cnt;
        issue("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 2);
        drain("sw");
        check32("sw_wr_count", wr_cnt - wr0, 32'd1);
        check32("sw_waddr", last_waddr, 32'd4);
        check32("sw_wdata", last_wdata, 32'hDEADBEEF);

        issue("lb", 1'b0, 3'b000, 32'h13, 32'd0, 1'b0, 32'hFFFFFFDE, 2);
        issue("lbu", 1'b0, 3'b100, 32'h13, 32'd0, 1'b0, 32'h000000DE, 2);
        issue("lh", 1'b0, 3'b001, 32'h12, 32'd0, 1'b0, 32'hFFFFDEAD, 2);
        issue("lhu", 1'b0, 3'b101, 32'h10, 32'd0, 1'b0, 32'h0000BEEF, 2);
        drain("loads");

        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue("sb", 1'b1, 3'b000, 32'h11, 32'h00000055, 1'b0, 32'd0, 3);
        drain("sb");
        check32("sb_rd_count", rd_cnt - rd0, 32'd1);
        check32("sb_wr_count", wr_cnt - wr0, 32'd1);
        check32("sb_wdata", last_wdata, 32'hDEAD55EF);

        issue("sh", 1'b1, 3'b001, 32'h12, 32'hFFFF1234, 1'b0, 32'd0, 3);
        issue("lw", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'h123455EF, 2);
        drain("sh_lw");

        wr0 = wr_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h000000AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check32("rmw_rd_read", {31'd0, mem_read}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check32("rst_mid_read", {31'd0, mem_read}, 32'd0);
        check32("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check32("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check32("post_rst_resp", {31'd0, resp_valid}, 32'd0);
        check32("post_rst_wr_count", wr_cnt - wr0, 32'd0);
        check32("post_rst_mem", tb_mem[4], 32'h123455EF);

        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue("err_lw_mis", 1'b0, 3'b010, 32'h12, 32'd0, 1'b1, 32'd0, 2);
        issue("err_sh_mis", 1'b1, 3'b001, 32'h01, 32'h1, 1'b1, 32'd0, 2);
        issue("err_lw_oor", 1'b0, 3'b010, 32'h1000, 32'd0, 1'b1, 32'd0, 2);
        issue("err_f3", 1'b0, 3'b011, 32'h10, 32'd0, 1'b1, 32'd0, 2);
        issue("err_sb_f3", 1'b1, 3'b100, 32'h10, 32'd0, 1'b1, 32'd0, 2);
        drain("errors");
        check32("err_rd_count", rd_cnt - rd0, 32'd0);
        check32("err_wr_count", wr_cnt - wr0, 32'd0);
        check32("err_mem", tb_mem[4], 32'h123455EF);

        issue("b2b_lw1", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'h123455EF, 2);
        acc1 = last_accept;
        issue("b2b_lw2", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'h123455EF, 2);
        check32("b2b_accept_gap", last_accept - acc1, 32'd2);
        drain("b2b");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
